// File: rtl/softmax_pkg.sv
// Shared defaults, lane types and the lane-D constant for the online-softmax
// accumulator slice.
package softmax_pkg;

    localparam int D_DEF       = 64;
    localparam int DW_DEF      = 16;
    localparam int VFW_DEF     = 8;
    localparam int SW_DEF      = 16;
    localparam int FW_DEF      = 8;
    localparam int MAX_LEN_DEF = 512;
    localparam int AW_DEF      = DW_DEF + $clog2(MAX_LEN_DEF) + 1;

    typedef logic signed [SW_DEF-1:0] score_t;
    typedef logic signed [DW_DEF-1:0] value_t;
    typedef logic signed [AW_DEF-1:0] acc_t;

    // Lane D carries the denominator: every token contributes 1.0 in value format
    function automatic int one_const(input int vfw);
        return 32'sd1 <<< vfw;
    endfunction

    localparam int ONE_DEF = one_const(VFW_DEF);

endpackage

// File: rtl/softmax_expmul_acc_scale.sv
// expmul_scale: x * 2^-d with d in Q.FW, using 2^-f ~= 1 - f/2 on the
// fractional part and an arithmetic shift on the integer part.
module expmul_scale #(
    parameter int AW = 19,
    parameter int SW = 16,
    parameter int FW = 8
) (
    input  logic signed [AW-1:0] x_i,
    input  logic        [SW:0]   d_i,
    output logic signed [AW-1:0] y_o
);
    localparam int PW = AW + FW + 1;
    localparam int KW = SW + 1 - FW;
    localparam logic [KW-1:0] K_LIMIT = KW'(AW);

    logic        [KW-1:0] k_s;
    logic        [FW-1:0] f_s;
    logic signed [PW-1:0] prod_s;
    logic signed [PW-1:0] corr_s;
    logic signed [AW-1:0] lin_s;
    logic signed [AW-1:0] shr_s;

    assign k_s    = d_i[SW:FW];
    assign f_s    = d_i[FW-1:0];
    assign prod_s = PW'(x_i) * PW'($signed({1'b0, f_s}));
    // |corr| < |x|, so the correction always fits back into AW bits
    assign corr_s = prod_s >>> (FW + 1);
    assign lin_s  = x_i - $signed(corr_s[AW-1:0]);
    assign shr_s  = lin_s >>> k_s;
    assign y_o    = (k_s >= K_LIMIT) ? {AW{1'b0}} : shr_s;

endmodule

// File: rtl/softmax_expmul_acc.sv
// Online-softmax accumulator: tracks running max m and rescaled lanes O/l per
// query row, emitting {O, l, m} through a one-deep output buffer.
module softmax_expmul_acc
    import softmax_pkg::*;
#(
    parameter int D       = D_DEF,
    parameter int DW      = DW_DEF,
    parameter int VFW     = VFW_DEF,
    parameter int SW      = SW_DEF,
    parameter int FW      = FW_DEF,
    parameter int MAX_LEN = MAX_LEN_DEF,
    parameter int AW      = DW + $clog2(MAX_LEN) + 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_vld,
    output logic                          in_rdy,
    input  logic [SW-1:0]                 in_s,
    input  logic [D*DW-1:0]               in_v,
    input  logic                          in_last,
    output logic                          out_vld,
    input  logic                          out_rdy,
    output logic [(D+1)*AW-1:0]           out_o,
    output logic [SW-1:0]                 out_m,
    output logic [$clog2(MAX_LEN+1)-1:0]  out_cnt,
    output logic                          out_trunc
);
    localparam int L  = D + 1;
    localparam int CW = $clog2(MAX_LEN + 1);
    localparam logic signed [AW-1:0] ONE_LANE = AW'(one_const(VFW));
    localparam logic [CW-1:0]        CNT_ONE  = CW'(32'd1);
    localparam logic [CW-1:0]        CNT_MAX  = CW'(MAX_LEN);

    function automatic logic signed [AW-1:0] sat_f(input logic signed [AW:0] v);
        if (v[AW] != v[AW-1]) begin
            sat_f = v[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
        end else begin
            sat_f = v[AW-1:0];
        end
    endfunction

    logic                 empty_q, empty_d;
    logic signed [SW-1:0] m_q, m_d;
    logic signed [AW-1:0] acc_q [L];
    logic signed [AW-1:0] acc_d [L];
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 out_vld_q, out_vld_d;
    logic [L*AW-1:0]      out_o_q, out_o_d;
    logic signed [SW-1:0] out_m_q, out_m_d;
    logic [CW-1:0]        out_cnt_q, out_cnt_d;
    logic                 out_trunc_q, out_trunc_d;

    logic                 in_rdy_s, accept_s, close_s;
    logic signed [SW-1:0] s_s, mn_s;
    logic [SW:0]          d_acc_s, d_in_s;
    logic [CW-1:0]        cnt_new_s;
    logic signed [AW-1:0] vin_s     [L];
    logic signed [AW-1:0] sa_s      [L];
    logic signed [AW-1:0] sv_s      [L];
    logic signed [AW:0]   sum_s     [L];
    logic signed [AW-1:0] acc_new_s [L];

    assign in_rdy_s  = !rst && (!out_vld_q || out_rdy);
    assign accept_s  = in_vld && in_rdy_s;
    assign s_s       = $signed(in_s);
    assign mn_s      = (empty_q || (s_s > m_q)) ? s_s : m_q;
    assign d_acc_s   = {mn_s[SW-1], mn_s} - {m_q[SW-1], m_q};
    assign d_in_s    = {mn_s[SW-1], mn_s} - {s_s[SW-1], s_s};
    assign cnt_new_s = empty_q ? CNT_ONE : (cnt_q + CNT_ONE);
    assign close_s   = accept_s && (in_last || (cnt_new_s == CNT_MAX));

    for (genvar i = 0; i < L; i++) begin : g_lane
        if (i < D) begin : g_val
            assign vin_s[i] = AW'($signed(in_v[i*DW +: DW]));
        end else begin : g_one
            assign vin_s[i] = ONE_LANE;
        end

        expmul_scale #(.AW(AW), .SW(SW), .FW(FW)) u_scale_acc (
            .x_i (acc_q[i]),
            .d_i (d_acc_s),
            .y_o (sa_s[i])
        );

        expmul_scale #(.AW(AW), .SW(SW), .FW(FW)) u_scale_in (
            .x_i (vin_s[i]),
            .d_i (d_in_s),
            .y_o (sv_s[i])
        );

        assign sum_s[i]     = {sa_s[i][AW-1], sa_s[i]} + {sv_s[i][AW-1], sv_s[i]};
        assign acc_new_s[i] = empty_q ? vin_s[i] : sat_f(sum_s[i]);
    end

    // Next state: a closing element lands in the output buffer, not the accumulator
    always_comb begin
        empty_d     = empty_q;
        m_d         = m_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_o_d     = out_o_q;
        out_m_d     = out_m_q;
        out_cnt_d   = out_cnt_q;
        out_trunc_d = out_trunc_q;
        if (out_vld_q && out_rdy) begin
            out_vld_d = 1'b0;
        end else begin
            out_vld_d = out_vld_q;
        end
        if (close_s) begin
            empty_d     = 1'b1;
            cnt_d       = {CW{1'b0}};
            out_vld_d   = 1'b1;
            out_m_d     = mn_s;
            out_cnt_d   = cnt_new_s;
            out_trunc_d = !in_last;
            for (int i = 0; i < L; i++) begin
                out_o_d[i*AW +: AW] = acc_new_s[i];
            end
        end else if (accept_s) begin
            empty_d = 1'b0;
            m_d     = mn_s;
            acc_d   = acc_new_s;
            cnt_d   = cnt_new_s;
        end else begin
            empty_d = empty_q;
        end
    end

    // State and output-buffer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            empty_q     <= 1'b1;
            m_q         <= {SW{1'b0}};
            cnt_q       <= {CW{1'b0}};
            for (int i = 0; i < L; i++) begin
                acc_q[i] <= {AW{1'b0}};
            end
            out_vld_q   <= 1'b0;
            out_o_q     <= {(L*AW){1'b0}};
            out_m_q     <= {SW{1'b0}};
            out_cnt_q   <= {CW{1'b0}};
            out_trunc_q <= 1'b0;
        end else begin
            empty_q     <= empty_d;
            m_q         <= m_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            out_vld_q   <= out_vld_d;
            out_o_q     <= out_o_d;
            out_m_q     <= out_m_d;
            out_cnt_q   <= out_cnt_d;
            out_trunc_q <= out_trunc_d;
        end
    end

    assign in_rdy    = in_rdy_s;
    assign out_vld   = out_vld_q;
    assign out_o     = out_o_q;
    assign out_m     = out_m_q;
    assign out_cnt   = out_cnt_q;
    assign out_trunc = out_trunc_q;

endmodule

// File: tb/tb_softmax_expmul_acc.sv
// Bench for softmax_expmul_acc: row-level softmax model plus directed vectors
// with hand-computed results.
module tb_softmax_expmul_acc;
    localparam int D       = 4;
    localparam int DW      = 16;
    localparam int VFW     = 8;
    localparam int SW      = 16;
    localparam int FW      = 8;
    localparam int MAX_LEN = 4;
    localparam int AW      = DW + $clog2(MAX_LEN) + 1;
    localparam int CW      = $clog2(MAX_LEN + 1);
    localparam int L       = D + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_vld;
    logic              in_rdy;
    logic [SW-1:0]     in_s;
    logic [D*DW-1:0]   in_v;
    logic              in_last;
    logic              out_vld;
    logic              out_rdy;
    logic [L*AW-1:0]   out_o;
    logic [SW-1:0]     out_m;
    logic [CW-1:0]     out_cnt;
    logic              out_trunc;

    softmax_expmul_acc #(.D(D), .DW(DW), .VFW(VFW), .SW(SW), .FW(FW), .MAX_LEN(MAX_LEN)) dut (
        .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy), .in_s(in_s), .in_v(in_v),
        .in_last(in_last), .out_vld(out_vld), .out_rdy(out_rdy), .out_o(out_o), .out_m(out_m),
        .out_cnt(out_cnt), .out_trunc(out_trunc)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit rnd_rdy = 1'b0;

    typedef struct {
        longint o [L];
        longint m;
        longint cnt;
        bit     trunc;
    } res_t;

    res_t   exp_q [$];
    bit     md_empty = 1'b1;
    longint md_m;
    longint md_acc [L];
    longint md_cnt;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint lane(input int i);
        logic [AW-1:0] raw;
        raw = out_o[i*AW +: AW];
        return longint'($signed(raw));
    endfunction

    // x * 2^-d, with 2^-f approximated as 1 - f/2
    function automatic longint scale(input longint x, input longint d);
        longint k, f, y;
        k = d / 256;
        f = d % 256;
        y = x - ((x * f) >>> 9);
        if (k >= AW) return 0;
        return y >>> k;
    endfunction

    function automatic longint sat(input longint v);
        longint hi, lo;
        hi = (longint'(1) <<< (AW - 1)) - 1;
        lo = -(longint'(1) <<< (AW - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    task automatic model_accept();
        longint s, mn;
        longint vin [L];
        logic [DW-1:0] rv;
        res_t r;
        s = longint'($signed(in_s));
        for (int i = 0; i < D; i++) begin
            rv = in_v[i*DW +: DW];
            vin[i] = longint'($signed(rv));
        end
        vin[D] = 256;
        if (md_empty) begin
            md_m = s;
            for (int i = 0; i < L; i++) md_acc[i] = vin[i];
            md_cnt = 1;
        end else begin
            mn = (s > md_m) ? s : md_m;
            for (int i = 0; i < L; i++)
                md_acc[i] = sat(scale(md_acc[i], mn - md_m) + scale(vin[i], mn - s));
            md_m = mn;
            md_cnt++;
        end
        md_empty = 1'b0;
        if (in_last || md_cnt == MAX_LEN) begin
            for (int i = 0; i < L; i++) r.o[i] = md_acc[i];
            r.m     = md_m;
            r.cnt   = md_cnt;
            r.trunc = !in_last;
            exp_q.push_back(r);
            md_empty = 1'b1;
        end
    endtask

    // Compare process: sampled on the falling edge, ahead of the rising edge it predicts
    initial begin
        res_t r;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                md_empty = 1'b1;
            end else begin
                chk("in_rdy_rule", longint'(in_rdy), longint'(!out_vld || out_rdy));
                chk("out_vld_model", longint'(out_vld), longint'(exp_q.size() != 0));
                if (out_vld && out_rdy && exp_q.size() != 0) begin
                    r = exp_q.pop_front();
                    for (int i = 0; i < L; i++) chk($sformatf("model_lane%0d", i), lane(i), r.o[i]);
                    chk("model_m", longint'($signed(out_m)), r.m);
                    chk("model_cnt", longint'(out_cnt), r.cnt);
                    chk("model_trunc", longint'(out_trunc), longint'(r.trunc));
                end
                if (in_vld && in_rdy) model_accept();
            end
        end
    end

    task automatic send(input longint s, input longint v0, input longint v1,
                        input longint v2, input longint v3, input bit last);
        bit got = 1'b0;
        in_vld  = 1'b1;
        in_s    = s[SW-1:0];
        in_v    = {v3[DW-1:0], v2[DW-1:0], v1[DW-1:0], v0[DW-1:0]};
        in_last = last;
        for (int n = 0; n < 50; n++) begin
            if (rnd_rdy) out_rdy = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (in_rdy) begin
                got = 1'b1;
                break;
            end
            @(posedge clk);
            #2;
        end
        chk("send_accepted", longint'(got), 1);
        @(posedge clk);
        #2;
        in_vld  = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic expect_out(input longint e0, input longint e1, input longint e2, input longint e3,
                              input longint e4, input longint em, input longint ecnt, input bit etr);
        @(negedge clk);
        chk("lit_vld", longint'(out_vld), 1);
        chk("lit_lane0", lane(0), e0);
        chk("lit_lane1", lane(1), e1);
        chk("lit_lane2", lane(2), e2);
        chk("lit_lane3", lane(3), e3);
        chk("lit_laneD", lane(4), e4);
        chk("lit_m", longint'($signed(out_m)), em);
        chk("lit_cnt", longint'(out_cnt), ecnt);
        chk("lit_trunc", longint'(out_trunc), longint'(etr));
        @(posedge clk);
        #2;
    endtask

    task automatic check_zero();
        chk("zero_vld", longint'(out_vld), 0);
        chk("zero_o", longint'(|out_o), 0);
        chk("zero_m", longint'(out_m), 0);
        chk("zero_cnt", longint'(out_cnt), 0);
        chk("zero_trunc", longint'(out_trunc), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; in_vld = 1'b0; in_s = '0; in_v = '0; in_last = 1'b0; out_rdy = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        @(negedge clk);
        chk("rdy_in_reset", longint'(in_rdy), 0);
        check_zero();
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        chk("rdy_after_reset", longint'(in_rdy), 1);
        @(posedge clk);
        #2;

        // Single-element row
        send(1280, 1, 2, 3, 4, 1'b1);
        expect_out(1, 2, 3, 4, 256, 1280, 1, 1'b0);

        // Equal scores
        send(0, 256, 256, 256, 256, 1'b0);
        send(0, 256, 256, 256, 256, 1'b1);
        expect_out(512, 512, 512, 512, 512, 0, 2, 1'b0);

        // Integer shift, both orders
        send(0, 256, 256, 256, 256, 1'b0);
        send(256, 0, 0, 0, 0, 1'b1);
        expect_out(128, 128, 128, 128, 384, 256, 2, 1'b0);
        send(256, 0, 0, 0, 0, 1'b0);
        send(0, 256, 256, 256, 256, 1'b1);
        expect_out(128, 128, 128, 128, 384, 256, 2, 1'b0);

        // Fractional shift
        send(0, 256, 256, 256, 256, 1'b0);
        send(128, 0, 0, 0, 0, 1'b1);
        expect_out(192, 192, 192, 192, 448, 128, 2, 1'b0);

        // Backpressure: row A held, row B stalls until out_rdy
        out_rdy = 1'b0;
        send(0, 10, 20, 30, 40, 1'b1);
        in_vld = 1'b1; in_s = 16'd0; in_v = {4{16'd1}}; in_last = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            chk("bp_rdy_low", longint'(in_rdy), 0);
            chk("bp_vld_held", longint'(out_vld), 1);
            chk("bp_lane0_stable", lane(0), 10);
            @(posedge clk);
            #2;
        end
        out_rdy = 1'b1;
        @(negedge clk);
        chk("bp_rdy_release", longint'(in_rdy), 1);
        chk("bp_rowA_lane3", lane(3), 40);
        @(posedge clk);
        #2;
        send(256, 3, 3, 3, 3, 1'b1);
        expect_out(3, 3, 3, 3, 384, 256, 2, 1'b0);

        // Reset drops a buffered result, then a partial row
        out_rdy = 1'b0;
        send(0, 9, 9, 9, 9, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #2;
        @(negedge clk);
        check_zero();
        @(posedge clk);
        #2;
        rst = 1'b0;
        out_rdy = 1'b1;
        send(0, 5, 5, 5, 5, 1'b0);
        send(0, 5, 5, 5, 5, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #2;
        @(negedge clk);
        check_zero();
        @(posedge clk);
        #2;
        rst = 1'b0;
        send(0, 7, 7, 7, 7, 1'b1);
        expect_out(7, 7, 7, 7, 256, 0, 1, 1'b0);

        // Truncation at MAX_LEN, fifth element starts a fresh row
        for (int n = 0; n < 4; n++) send(0, 1, 2, 3, 4, 1'b0);
        expect_out(4, 8, 12, 16, 1024, 0, 4, 1'b1);
        send(0, 1, 2, 3, 4, 1'b0);
        send(0, 1, 2, 3, 4, 1'b1);
        expect_out(2, 4, 6, 8, 512, 0, 2, 1'b0);

        // Extreme values over a full row
        for (int n = 0; n < 4; n++) send(0, 32767, 32767, -32768, -32768, 1'b0);
        expect_out(131068, 131068, -131072, -131072, 1024, 0, 4, 1'b1);

        // Mixed scores and random backpressure, checked by the model only
        rnd_rdy = 1'b1;
        for (int n = 0; n < 40; n++) begin
            send(longint'($urandom_range(0, 1535)) - 768,
                 longint'($urandom_range(0, 60000)) - 30000,
                 longint'($urandom_range(0, 4000)) - 2000,
                 longint'($urandom_range(0, 600)) - 300,
                 longint'($urandom_range(0, 65535)) - 32768,
                 ($urandom_range(0, 2) == 0));
        end
        rnd_rdy = 1'b0;
        out_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        @(negedge clk);
        chk("drain_empty", longint'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
